// File: rtl/onchip_arb_pkg.sv
// Shared constants and index type for the on-chip RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package onchip_arb_pkg;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int MEM_DEPTH = 1024;
    localparam int MAX_REQ   = 4;
    localparam int PTR_W     = $clog2(MAX_REQ);

    typedef logic [PTR_W-1:0] req_idx_t;

    // Round-robin successor of index i for a ring of n requesters.
    function automatic req_idx_t next_idx(input req_idx_t i, input int n);
        return (int'(i) == n - 1) ? '0 : req_idx_t'(i + 1'b1);
    endfunction
endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Requester-side Avalon-MM buses plus the RAM s1 port, bundled for the arbiter.
// Latency: n/a (wiring only).
// Backpressure: m_waitrequest per requester; the RAM side never stalls.
interface onchip_mem_arbiter_if #(parameter int NUM_REQ = 2);
    import onchip_arb_pkg::*;

    logic [NUM_REQ*ADDR_W-1:0] m_address;
    logic [NUM_REQ*BE_W-1:0]   m_byteenable;
    logic [NUM_REQ*DATA_W-1:0] m_writedata;
    logic [NUM_REQ-1:0]        m_read;
    logic [NUM_REQ-1:0]        m_write;
    logic [NUM_REQ-1:0]        m_waitrequest;
    logic [DATA_W-1:0]         m_readdata;
    logic [NUM_REQ-1:0]        m_readdatavalid;

    logic [ADDR_W-1:0]         mem_address;
    logic [BE_W-1:0]           mem_byteenable;
    logic [DATA_W-1:0]         mem_writedata;
    logic                      mem_chipselect;
    logic                      mem_write;
    logic                      mem_clken;
    logic [DATA_W-1:0]         mem_readdata;

    // Arbiter view.
    modport slave (
        input  m_address, m_byteenable, m_writedata, m_read, m_write, mem_readdata,
        output m_waitrequest, m_readdata, m_readdatavalid,
               mem_address, mem_byteenable, mem_writedata,
               mem_chipselect, mem_write, mem_clken
    );

    // Requesters and RAM view.
    modport master (
        output m_address, m_byteenable, m_writedata, m_read, m_write, mem_readdata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
               mem_address, mem_byteenable, mem_writedata,
               mem_chipselect, mem_write, mem_clken
    );
endinterface

// File: rtl/onchip_arb_rr_picker.sv
// One-hot grant picker: round-robin from ptr with ONCHIP_ARB_RR_EN, else lowest index.
// Latency: purely combinational.
// Backpressure: none; an empty active vector yields an all-zero grant.
module onchip_arb_rr_picker
    import onchip_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] active,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] grant
);
    logic found;

`ifdef ONCHIP_ARB_RR_EN
    // Scan the ring starting at ptr; first active requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == (int'(ptr) + k) % NUM_REQ) && active[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`else
    // Pointer is meaningless for fixed priority.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest active index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && active[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port 1024x32 RAM among NUM_REQ requesters (ONCHIP_ARB_RR_EN: round-robin, else fixed).
// Latency: 0-cycle accept when uncontended; readdatavalid exactly 1 cycle after the accepting cycle.
// Backpressure: m_waitrequest high on every non-granted requester; read returns never stall.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave bus
);
    logic               arb_ready;
    req_idx_t           ptr;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] grant;
    req_idx_t           gidx;
    logic               rd_accept;
    logic               rd_pending;
    req_idx_t           rd_owner;

    // No grants until the first edge after reset release.
    assign active = arb_ready ? (bus.m_read | bus.m_write) : '0;

    onchip_arb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .active (active),
        .ptr    (ptr),
        .grant  (grant)
    );

    // Steer the granted requester's command onto the RAM port; zeros when idle.
    always_comb begin
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        bus.mem_write      = 1'b0;
        rd_accept          = 1'b0;
        gidx               = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                bus.mem_address    = bus.m_address[i*ADDR_W +: ADDR_W];
                bus.mem_byteenable = bus.m_byteenable[i*BE_W +: BE_W];
                bus.mem_writedata  = bus.m_writedata[i*DATA_W +: DATA_W];
                bus.mem_write      = bus.m_write[i];
                rd_accept          = bus.m_read[i] & ~bus.m_write[i];
                gidx               = req_idx_t'(i);
            end
        end
    end

    assign bus.mem_chipselect = |grant;
    assign bus.mem_clken      = arb_ready;
    assign bus.m_waitrequest  = ~grant;
    assign bus.m_readdata     = bus.mem_readdata;

    // Return strobe goes to whoever issued last cycle's read.
    always_comb begin
        bus.m_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.m_readdatavalid[i] = rd_pending && (rd_owner == req_idx_t'(i));
        end
    end

    // Ready flag and one-deep read return tracker; reset kills any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_ready  <= 1'b0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
        end else begin
            arb_ready  <= 1'b1;
            rd_pending <= rd_accept;
            if (rd_accept) begin
                rd_owner <= gidx;
            end
        end
    end

`ifdef ONCHIP_ARB_RR_EN
    // Advance the search start past the last winner; hold on idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= next_idx(gidx, NUM_REQ);
        end
    end
`else
    assign ptr = '0;
`endif
endmodule
